ntt_nwc_stage_ctrl: RTL
=======================

// Module: ntt_nwc_stage_ctrl
// PURPOSE
//  Sequencer directly upstream of BU2_NWC for an in-place Cooley-Tukey negacyclic NTT of N = 2**N_LOG coeffs.
//  Each cycle it issues one butterfly: coefficient-RAM read pair (a,b) plus a bit-reversed psi twiddle-ROM address.
//  A valid strobe is aligned to RAM/ROM read data at the butterfly inputs; write-back addresses are aligned to BU_a/BU_b.
//  It inserts a drain gap between stages so stage s+1 never reads a word that stage s has not yet written.
// PARAMETERS
//  N_LOG   3  log2 of transform size N; legal range 2..12
//  RD_LAT  1  read latency of coefficient RAM and twiddle ROM (cycles, identical for both)
//  BU_LAT  2  BU2_NWC input-to-output latency (cycles)
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous active-high reset
//  start      in   1       start one full transform; sampled only in IDLE
//  rd_en      out  1       coefficient RAM and twiddle ROM read enable (one butterfly issued)
//  rd_addr_a  out  N_LOG   coefficient address feeding BU in1
//  rd_addr_b  out  N_LOG   coefficient address feeding BU in2
//  tw_addr    out  N_LOG   twiddle ROM address (psi_rev table index m+i)
//  bu_valid   out  1       rd_en delayed RD_LAT; RAM/ROM data at BU inputs is valid
//  wr_en      out  1       rd_en delayed D = RD_LAT+BU_LAT; BU_a/BU_b are valid
//  wr_addr_a  out  N_LOG   rd_addr_a delayed D; destination of BU_a
//  wr_addr_b  out  N_LOG   rd_addr_b delayed D; destination of BU_b
//  stage_idx  out  N_LOG   current stage s (0..N_LOG-1), held during DRAIN
//  busy       out  1       high in ISSUE and DRAIN
//  done       out  1       one-cycle pulse at transform completion
// BEHAVIOUR
//  Reset: rst at any edge forces IDLE and drives every output to 0.
//   Reset clears all delay-line stages, so no wr_en/bu_valid pulse follows reset.
//   rst has priority over start.
//  FSM: IDLE -> ISSUE (start=1) -> DRAIN (k==N/2-1) -> ISSUE (s<N_LOG-1, s++) or DONE (s==N_LOG-1) -> IDLE.
//  IDLE: s=0, k=0; all outputs 0.
//  ISSUE: rd_en=1 every cycle.
//   Butterfly counter k runs 0..N/2-1.
//   Derived values: m=2**s, t=2**(N_LOG-1-s), i=k>>(N_LOG-1-s), j=k&(t-1).
//   Addresses: rd_addr_a=(i<<(N_LOG-s))|j; rd_addr_b=rd_addr_a+t; tw_addr=m+i. All unsigned, no wrap possible.
//  DRAIN: rd_en=0 for exactly D cycles.
//   Guarantees the last wr_en of stage s lands strictly before the first read of stage s+1.
//   The RAM is write-first; no forwarding is required.
//  DONE: done=1 and busy=0 for one cycle, then IDLE.
//  Delay lines: bu_valid/wr_en/wr_addr_* are pure shift registers of rd_en/rd_addr_*.
//   They keep shifting through DRAIN and DONE.
//   The final wr_en occurs in the last DRAIN cycle, before done.
//  start while busy or in DONE: ignored, no effect.
//  start held high: a new transform begins on the first IDLE cycle.
//  Timing: start sampled at edge 0 -> first rd_en in cycle 1.
//   Stage length is N/2+D cycles; done occurs in cycle N_LOG*(N/2+D)+1.
// TESTING
//  T1 N_LOG=3, D=3, start pulse -> stage 0 rd pairs (0,4)(1,5)(2,6)(3,7), tw_addr 1,1,1,1, rd_en cycles 1..4.
//  T2 same run, stage 1 -> pairs (0,2)(1,3)(4,6)(5,7), tw 2,2,3,3 in cycles 8..11.
//     Stage 2 -> pairs (0,1)(2,3)(4,5)(6,7), tw 4,5,6,7 in cycles 15..18.
//     done=1 only in cycle 22; busy=1 cycles 1..21.
//  T3 hazard check: for every stage, last wr_en cycle < first rd_en cycle of the next stage.
//     wr_addr_a/b equal rd_addr_a/b shifted by exactly 3 cycles; bu_valid equals rd_en shifted by 1.
//  T4 golden model: RAM + ROM + BU2_NWC model, N_LOG=8, random q-bounded inputs, q=12289.
//     Final RAM contents equal the software NWC NTT.
//  T5 rst asserted in cycle 10 (mid stage 1) -> cycle 11 all outputs 0, no later wr_en.
//     A new start then reproduces T1 exactly.
//  T6 start pulsed again in cycles 5 and 22 -> ignored, with identical schedule.
//     start held high continuously -> back-to-back transforms with one IDLE cycle between done and the next rd_en.

Source files
------------

// File: rtl/ntt_nwc_stage_ctrl_if.sv
// Handshake/bus bundle between the NWC NTT stage sequencer and its RAM/ROM/BU datapath.
// The master side is the sequencer; the slave side is the datapath that consumes addresses and strobes.
interface ntt_nwc_stage_ctrl_if #(
  parameter int N_LOG = 3
);
  logic             start;
  logic             rd_en;
  logic [N_LOG-1:0] rd_addr_a;
  logic [N_LOG-1:0] rd_addr_b;
  logic [N_LOG-1:0] tw_addr;
  logic             bu_valid;
  logic             wr_en;
  logic [N_LOG-1:0] wr_addr_a;
  logic [N_LOG-1:0] wr_addr_b;
  logic [N_LOG-1:0] stage_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    output rd_en, rd_addr_a, rd_addr_b, tw_addr, bu_valid,
           wr_en, wr_addr_a, wr_addr_b, stage_idx, busy, done
  );

  modport slave (
    output start,
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr, bu_valid,
           wr_en, wr_addr_a, wr_addr_b, stage_idx, busy, done
  );
endinterface

// File: rtl/ntt_nwc_stage_ctrl.sv
// Butterfly sequencer for an in-place Cooley-Tukey negacyclic NTT: issues one read pair plus twiddle per cycle,
// delays strobes/addresses to the BU inputs and write-back, and drains between stages to avoid RAW hazards.
module ntt_nwc_stage_ctrl #(
  parameter int N_LOG  = 3,
  parameter int RD_LAT = 1,
  parameter int BU_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_nwc_stage_ctrl_if.master io_ctrl
);

  localparam int D    = RD_LAT + BU_LAT;
  localparam int HALF = 1 << (N_LOG - 1);
  localparam int KW   = N_LOG - 1;
  localparam int DW   = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [KW-1:0]    r_k;
  logic [DW-1:0]    r_drain;
  logic [N_LOG-1:0] r_stage;

  logic             w_kLast;
  logic             w_drainLast;
  logic             w_stageLast;
  logic             w_rdEn;
  logic             w_busy;
  logic             w_done;

  logic [N_LOG-1:0] w_tShift;
  logic [N_LOG-1:0] w_aShift;
  logic [N_LOG-1:0] w_kExt;
  logic [N_LOG-1:0] w_t;
  logic [N_LOG-1:0] w_i;
  logic [N_LOG-1:0] w_j;
  logic [N_LOG-1:0] w_addrA;
  logic [N_LOG-1:0] w_addrB;
  logic [N_LOG-1:0] w_tw;
  logic [N_LOG-1:0] w_rdAddrA;
  logic [N_LOG-1:0] w_rdAddrB;
  logic [N_LOG-1:0] w_twAddr;

  logic [D-1:0]     r_enPipe;
  logic [N_LOG-1:0] r_aPipe [D];
  logic [N_LOG-1:0] r_bPipe [D];

  assign w_kLast     = (r_k == KW'(HALF - 1));
  assign w_drainLast = (r_drain == DW'(D - 1));
  assign w_stageLast = (r_stage == N_LOG'(N_LOG - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_rdEn      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_ctrl.start) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        w_rdEn = 1'b1;
        w_busy = 1'b1;
        if (w_kLast) w_nextState = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_drainLast) w_nextState = w_stageLast ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Stage index advances only when a drain completes, so it stays put for the whole drain gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_drain <= '0;
      r_stage <= '0;
    end else begin
      case (r_state)
        S_ISSUE: begin
          r_k     <= w_kLast ? '0 : r_k + KW'(1);
          r_drain <= '0;
        end
        S_DRAIN: begin
          r_drain <= r_drain + DW'(1);
          if (w_drainLast) begin
            r_drain <= '0;
            if (!w_stageLast) r_stage <= r_stage + N_LOG'(1);
          end
        end
        default: begin
          r_k     <= '0;
          r_drain <= '0;
          r_stage <= '0;
        end
      endcase
    end
  end

  // k splits into group i (high bits) and offset j (low bits); the pair straddles a gap of t words.
  always_comb begin
    w_tShift = N_LOG'(N_LOG - 1) - r_stage;
    w_aShift = N_LOG'(N_LOG) - r_stage;
    w_kExt   = N_LOG'(r_k);
    w_t      = N_LOG'(1) << w_tShift;
    w_i      = w_kExt >> w_tShift;
    w_j      = w_kExt & (w_t - N_LOG'(1));
    w_addrA  = (w_i << w_aShift) | w_j;
    w_addrB  = w_addrA + w_t;
    w_tw     = (N_LOG'(1) << r_stage) + w_i;
  end

  assign w_rdAddrA = w_rdEn ? w_addrA : '0;
  assign w_rdAddrB = w_rdEn ? w_addrB : '0;
  assign w_twAddr  = w_rdEn ? w_tw    : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enPipe <= '0;
      for (int n = 0; n < D; n++) begin
        r_aPipe[n] <= '0;
        r_bPipe[n] <= '0;
      end
    end else begin
      r_enPipe[0] <= w_rdEn;
      r_aPipe[0]  <= w_rdAddrA;
      r_bPipe[0]  <= w_rdAddrB;
      for (int n = 1; n < D; n++) begin
        r_enPipe[n] <= r_enPipe[n-1];
        r_aPipe[n]  <= r_aPipe[n-1];
        r_bPipe[n]  <= r_bPipe[n-1];
      end
    end
  end

  assign io_ctrl.rd_en     = w_rdEn;
  assign io_ctrl.rd_addr_a = w_rdAddrA;
  assign io_ctrl.rd_addr_b = w_rdAddrB;
  assign io_ctrl.tw_addr   = w_twAddr;
  assign io_ctrl.bu_valid  = r_enPipe[RD_LAT-1];
  assign io_ctrl.wr_en     = r_enPipe[D-1];
  assign io_ctrl.wr_addr_a = r_aPipe[D-1];
  assign io_ctrl.wr_addr_b = r_bPipe[D-1];
  assign io_ctrl.stage_idx = r_stage;
  assign io_ctrl.busy      = w_busy;
  assign io_ctrl.done      = w_done;

endmodule
